// File: rtl/sme_pkg.sv
// Shared constants and state encoding for the string matching engine.
package sme_pkg;

  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam logic [7:0] CHAR_CARET  = 8'h5E;
  localparam logic [7:0] CHAR_DOLLAR = 8'h24;
  localparam logic [7:0] CHAR_DOT    = 8'h2E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STR,
    S_PAT,
    S_EVAL,
    S_OUT
  } sme_state_e;

endpackage

// File: rtl/sme_vec_reduce.sv
// Lowest-set-bit encoder and popcount over the candidate vector (combinational).
module sme_vec_reduce #(
  parameter int unsigned STR_DEPTH = 32
) (
  input  logic [STR_DEPTH-1:0]           i_vec,
  output logic                           o_any_c,
  output logic [$clog2(STR_DEPTH)-1:0]   o_low_c,
  output logic [$clog2(STR_DEPTH+1)-1:0] o_cnt_c
);
  localparam int unsigned IDX_W = $clog2(STR_DEPTH);
  localparam int unsigned CNT_W = $clog2(STR_DEPTH+1);

  assign o_any_c = |i_vec;

  always_comb begin
    o_low_c = '0;
    o_cnt_c = '0;
    for (int i = int'(STR_DEPTH) - 1; i >= 0; i--) begin
      if (i_vec[i]) o_low_c = IDX_W'(i);
    end
    for (int i = 0; i < int'(STR_DEPTH); i++) begin
      o_cnt_c = o_cnt_c + CNT_W'(i_vec[i]);
    end
  end

endmodule

// File: rtl/sme_multi.sv
// String matching engine: buffers a string, then shift-and matches a streamed
// pattern with '.', leading '^' and trailing '$' support.
module sme_multi
  import sme_pkg::*;
#(
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned STR_DEPTH = 32,
  parameter int unsigned PAT_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHAR_W-1:0]              chardata,
  input  logic                           isstring,
  input  logic                           ispattern,
  output logic                           valid,
  output logic                           match,
  output logic [$clog2(STR_DEPTH)-1:0]   match_index,
  output logic [$clog2(STR_DEPTH+1)-1:0] match_count,
  output logic                           str_ovf,
  output logic                           pat_ovf
);
  localparam int unsigned IDX_W  = $clog2(STR_DEPTH);
  localparam int unsigned LEN_W  = $clog2(STR_DEPTH+1);
  localparam int unsigned NTOK_W = $clog2(PAT_DEPTH+2);

  localparam logic [CHAR_W-1:0] C_SPACE  = CHAR_W'(CHAR_SPACE);
  localparam logic [CHAR_W-1:0] C_CARET  = CHAR_W'(CHAR_CARET);
  localparam logic [CHAR_W-1:0] C_DOLLAR = CHAR_W'(CHAR_DOLLAR);
  localparam logic [CHAR_W-1:0] C_DOT    = CHAR_W'(CHAR_DOT);

  sme_state_e               r_state, w_state, w_state_nx;
  logic [CHAR_W-1:0]        r_str [STR_DEPTH];
  logic [LEN_W-1:0]         r_len, w_len_nx;
  logic                     r_str_ovf, w_str_ovf_nx;
  logic [STR_DEPTH-1:0]     r_cand, w_cand_nx;
  logic [NTOK_W-1:0]        r_ntok, w_ntok_nx, w_ntok_inc, w_fin_ntok;
  logic                     r_caret, w_caret_nx, r_seen, w_seen_nx;
  logic                     r_pend_vld, w_pend_vld_nx;
  logic [CHAR_W-1:0]        r_pend_tok, w_pend_tok_nx;
  logic                     w_str_we, w_consume, w_fresh, w_out_ld;
  logic [IDX_W-1:0]         w_str_addr;
  logic [STR_DEPTH-1:0]     w_eq, w_inlen, w_ws, w_prev, w_nsp, w_last;
  logic [STR_DEPTH-1:0]     w_step, w_filt, w_fin_cand;
  logic                     w_any, w_pat_ovf, w_degen;
  logic [IDX_W-1:0]         w_low;
  logic [LEN_W-1:0]         w_cnt;
  logic                     w_valid_nx, w_match_nx, w_sovf_nx, w_povf_nx;
  logic [IDX_W-1:0]         w_index_nx;
  logic [LEN_W-1:0]         w_count_nx;

  // The first ispattern=0 cycle after a pattern is the evaluation cycle.
  assign w_state = (r_state == S_PAT && !ispattern) ? S_EVAL : r_state;

  for (genvar g = 0; g < int'(STR_DEPTH); g++) begin : g_pos
    assign w_eq[g]    = (r_pend_tok == C_DOT) || (r_str[g] == r_pend_tok);
    assign w_inlen[g] = 32'(g) < 32'(r_len);
    assign w_last[g]  = (32'(g) + 32'd1) == 32'(r_len);
    if (g == 0) begin : g_lo
      assign w_ws[g]   = 1'b1;
      assign w_prev[g] = 1'b0;
    end else begin : g_mid
      assign w_ws[g]   = r_str[g-1] == C_SPACE;
      assign w_prev[g] = r_cand[g-1];
    end
    if (g == int'(STR_DEPTH) - 1) begin : g_hi
      assign w_nsp[g] = 1'b0;
    end else begin : g_nhi
      assign w_nsp[g] = r_str[g+1] == C_SPACE;
    end
  end

  // Tokens are applied one cycle late so a trailing '$' can be recognised.
  assign w_step     = (r_ntok == '0) ? (w_inlen & w_eq & (r_caret ? w_ws : '1))
                                     : (w_prev & w_eq & w_inlen);
  assign w_filt     = r_cand & (w_last | w_nsp);
  assign w_ntok_inc = (32'(r_ntok) > 32'(PAT_DEPTH)) ? r_ntok : r_ntok + NTOK_W'(1);
  assign w_fin_cand = !r_pend_vld ? r_cand : (r_pend_tok == C_DOLLAR) ? w_filt : w_step;
  assign w_fin_ntok = (r_pend_vld && r_pend_tok != C_DOLLAR) ? w_ntok_inc : r_ntok;
  assign w_pat_ovf  = 32'(w_fin_ntok) > 32'(PAT_DEPTH);
  assign w_degen    = (w_fin_ntok == '0) || (32'(w_fin_ntok) > 32'(r_len)) || w_pat_ovf;

  sme_vec_reduce #(.STR_DEPTH(STR_DEPTH)) u_reduce (
    .i_vec   (w_fin_cand),
    .o_any_c (w_any),
    .o_low_c (w_low),
    .o_cnt_c (w_cnt)
  );

  always_comb begin
    w_state_nx   = w_state;
    w_str_we     = 1'b0;
    w_str_addr   = IDX_W'(r_len);
    w_len_nx     = r_len;
    w_str_ovf_nx = r_str_ovf;
    w_consume    = 1'b0;
    w_fresh      = 1'b0;
    w_out_ld     = 1'b0;
    case (w_state)
      S_IDLE, S_OUT: begin
        if (isstring) begin
          w_state_nx   = S_STR;
          w_str_we     = 1'b1;
          w_str_addr   = '0;
          w_len_nx     = LEN_W'(1);
          w_str_ovf_nx = 1'b0;
        end else if (ispattern) begin
          w_state_nx = S_PAT;
          w_consume  = 1'b1;
          w_fresh    = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_STR: begin
        if (isstring) begin
          if (32'(r_len) < 32'(STR_DEPTH)) begin
            w_str_we = 1'b1;
            w_len_nx = r_len + LEN_W'(1);
          end else begin
            w_str_ovf_nx = 1'b1;
          end
        end else if (ispattern) begin
          w_state_nx = S_PAT;
          w_consume  = 1'b1;
          w_fresh    = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_PAT:   w_consume = 1'b1;
      S_EVAL: begin
        w_state_nx = S_OUT;
        w_out_ld   = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Pattern token context.
  always_comb begin
    w_cand_nx     = r_cand;
    w_ntok_nx     = r_ntok;
    w_caret_nx    = r_caret;
    w_seen_nx     = r_seen;
    w_pend_vld_nx = r_pend_vld;
    w_pend_tok_nx = r_pend_tok;
    if (w_consume) begin
      if (w_fresh) begin
        w_cand_nx     = '0;
        w_ntok_nx     = '0;
        w_caret_nx    = 1'b0;
        w_seen_nx     = 1'b0;
        w_pend_vld_nx = 1'b0;
      end
      if (!w_seen_nx && chardata == C_CARET) begin
        w_caret_nx = 1'b1;
        w_seen_nx  = 1'b1;
      end else begin
        if (w_pend_vld_nx) begin
          w_cand_nx = w_step;
          w_ntok_nx = w_ntok_inc;
        end
        w_seen_nx     = 1'b1;
        w_pend_vld_nx = 1'b1;
        w_pend_tok_nx = chardata;
      end
    end else if (w_out_ld) begin
      w_cand_nx     = w_fin_cand;
      w_ntok_nx     = w_fin_ntok;
      w_pend_vld_nx = 1'b0;
    end
  end

  always_comb begin
    w_valid_nx = 1'b0;
    w_match_nx = match;
    w_index_nx = match_index;
    w_count_nx = match_count;
    w_sovf_nx  = str_ovf;
    w_povf_nx  = pat_ovf;
    if (w_out_ld) begin
      w_valid_nx = 1'b1;
      w_match_nx = !w_degen && w_any;
      w_index_nx = (w_degen || !w_any) ? '0
                 : IDX_W'(32'(w_low) + 32'd1 - 32'(w_fin_ntok));
      w_count_nx = w_degen ? '0 : w_cnt;
      w_sovf_nx  = r_str_ovf;
      w_povf_nx  = w_pat_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_str_ovf   <= 1'b0;
      r_cand      <= '0;
      r_ntok      <= '0;
      r_caret     <= 1'b0;
      r_seen      <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_tok  <= '0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      match_count <= '0;
      str_ovf     <= 1'b0;
      pat_ovf     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_len       <= w_len_nx;
      r_str_ovf   <= w_str_ovf_nx;
      r_cand      <= w_cand_nx;
      r_ntok      <= w_ntok_nx;
      r_caret     <= w_caret_nx;
      r_seen      <= w_seen_nx;
      r_pend_vld  <= w_pend_vld_nx;
      r_pend_tok  <= w_pend_tok_nx;
      valid       <= w_valid_nx;
      match       <= w_match_nx;
      match_index <= w_index_nx;
      match_count <= w_count_nx;
      str_ovf     <= w_sovf_nx;
      pat_ovf     <= w_povf_nx;
    end
  end

  // String storage needs no reset; r_len bounds every read.
  always_ff @(posedge clk) begin
    if (w_str_we) r_str[w_str_addr] <= chardata;
  end

endmodule
